phase_sequencer: RTL and testbench

//  Generates the one-hot instruction phase (IF/DE/EX/WB) that drives the controller's cstate input.

---
 rtl/kappa3_pkg.sv | 52 +++++
 rtl/phase_sequencer_checker.sv | 24 ++
 rtl/wait_timer.sv | 41 ++++
 rtl/phase_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_phase_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/kappa3_pkg.sv
// -----------------------------------------------------------------------------
// kappa3_pkg
// Shared definitions for the kappa3 core control path: the one-hot phase
// codes driven onto the controller's cstate input, the instruction
// sequencer state encoding, and the opcode constants the controller uses
// to decide which phases need the memory port.
// -----------------------------------------------------------------------------
package kappa3_pkg;

    // One-hot instruction phase codes (cstate)
    localparam logic [3:0] PH_NONE = 4'b0000;
    localparam logic [3:0] PH_IF   = 4'b0001;
    localparam logic [3:0] PH_DE   = 4'b0010;
    localparam logic [3:0] PH_EX   = 4'b0100;
    localparam logic [3:0] PH_WB   = 4'b1000;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_DE   = 3'd2,
        ST_EX   = 3'd3,
        ST_WB   = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Controller opcode classes
    localparam logic [3:0] OP_ALU    = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h1;
    localparam logic [3:0] OP_STORE  = 4'h2;
    localparam logic [3:0] OP_BRANCH = 4'h3;
    localparam logic [3:0] OP_JUMP   = 4'h4;

    // WB needs the memory port only for loads and stores
    function automatic logic wb_needs_mem(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Phase code shown on cstate while sitting in a given state
    function automatic logic [3:0] phase_of(input state_t s);
        logic [3:0] ph;
        case (s)
            ST_IF:   ph = PH_IF;
            ST_DE:   ph = PH_DE;
            ST_EX:   ph = PH_EX;
            ST_WB:   ph = PH_WB;
            default: ph = PH_NONE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/phase_sequencer_checker.sv
// -----------------------------------------------------------------------------
// phase_sequencer_checker
// Invariants on the sequencer outputs.
// Ports (all inputs): clock, reset, cstate, phase_done, stall, halted.
// -----------------------------------------------------------------------------
module phase_sequencer_checker (
    input logic       clock,
    input logic       reset,
    input logic [3:0] cstate,
    input logic       phase_done,
    input logic       stall,
    input logic       halted
);

    // cstate one-hot or zero; a phase is never both done and stalled; idle shows no phase
    always @(posedge clock) begin
        if (!reset) begin
            assert ($onehot0(cstate));
            assert (!(phase_done && stall));
            assert (!halted || (cstate == 4'b0000));
        end
    end

endmodule

// File: rtl/wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
// Counts stalled cycles within one memory phase and flags when the count has
// reached WAIT_MAX.
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   inc           count one more stalled cycle
//   clr           return the count to zero (wins over inc)
//   expired       count == WAIT_MAX
// -----------------------------------------------------------------------------
module wait_timer #(
    parameter int TW       = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam logic [TW-1:0] LIMIT = TW'(WAIT_MAX);

    logic [TW-1:0] count_r;

    // Stall counter; holds at LIMIT so it can never wrap back to zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != LIMIT)) begin
            count_r <= count_r + TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LIMIT);

endmodule

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
// Steps the controller through IF/DE/EX/WB, holding IF and WB while memory
// is busy, running freely or one instruction at a time, halting only at
// instruction boundaries, counting retired instructions and trapping memory
// timeouts into a sticky error state.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   run            level, execute instructions back-to-back
//   step           pulse, execute exactly one instruction
//   stop_req       level, halt at the next instruction boundary
//   clear          pulse, leave ERR and clear timeout_err
//   mem_req        current phase needs memory (controller-decoded)
//   mem_ack        memory completes the access this cycle
//   cstate[3:0]    one-hot phase, 0000 when idle or in error (registered)
//   phase_done     last cycle of the current phase
//   stall          phase held waiting for mem_ack
//   halted         sequencer idle (registered)
//   timeout_err    sticky memory timeout flag (registered)
//   retired[31:0]  completed WB phases, wraps (registered)
// -----------------------------------------------------------------------------
module phase_sequencer
    import kappa3_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int TW       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic        stop_req,
    input  logic        clear,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic [3:0]  cstate,
    output logic        phase_done,
    output logic        stall,
    output logic        halted,
    output logic        timeout_err,
    output logic [31:0] retired
);

    state_t      state_r;
    logic [3:0]  cstate_r;
    logic        halted_r;
    logic        timeout_err_r;
    logic [31:0] retired_r;
    logic        step_pend_r;
    logic        step_inst_r;   // current instruction was started by step

    logic mem_phase_s;
    logic stall_s;
    logic phase_done_s;
    logic timeout_s;
    logic expired_s;
    logic tmr_inc_s;
    logic tmr_clr_s;

    // Phase completion and stall decode. mem_ack only reaches phase_done/stall;
    // cstate comes straight from a register.
    always_comb begin
        mem_phase_s  = 1'b0;
        stall_s      = 1'b0;
        phase_done_s = 1'b0;
        mem_phase_s  = (state_r == ST_IF) || (state_r == ST_WB);
        if (mem_phase_s) begin
            if (mem_req) begin
                stall_s      = ~mem_ack;
                phase_done_s = mem_ack;
            end else begin
                stall_s      = 1'b0;
                phase_done_s = 1'b1;
            end
        end else if ((state_r == ST_DE) || (state_r == ST_EX)) begin
            phase_done_s = 1'b1;
        end else begin
            phase_done_s = 1'b0;
        end
        // stall_s already excludes mem_ack, so a late ack beats the timeout
        timeout_s = stall_s & expired_s;
        tmr_inc_s = stall_s;
        tmr_clr_s = ~stall_s | expired_s;
    end

    wait_timer #(
        .TW       (TW),
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .inc     (tmr_inc_s),
        .clr     (tmr_clr_s),
        .expired (expired_s)
    );

    // Sequencer FSM with step latch, retire counter and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cstate_r      <= PH_NONE;
            halted_r      <= 1'b1;
            timeout_err_r <= 1'b0;
            retired_r     <= 32'd0;
            step_pend_r   <= 1'b0;
            step_inst_r   <= 1'b0;
        end else begin
            step_pend_r <= step_pend_r | step;
            case (state_r)
                ST_IDLE: begin
                    // step outranks stop_req
                    if (step || step_pend_r || (run && !stop_req)) begin
                        state_r     <= ST_IF;
                        cstate_r    <= PH_IF;
                        halted_r    <= 1'b0;
                        step_pend_r <= 1'b0;
                        step_inst_r <= step | step_pend_r;
                    end
                end
                ST_IF: begin
                    if (timeout_s) begin
                        state_r       <= ST_ERR;
                        cstate_r      <= PH_NONE;
                        timeout_err_r <= 1'b1;
                        step_pend_r   <= 1'b0;
                        step_inst_r   <= 1'b0;
                    end else if (phase_done_s) begin
                        state_r  <= ST_DE;
                        cstate_r <= PH_DE;
                    end
                end
                ST_DE: begin
                    state_r  <= ST_EX;
                    cstate_r <= PH_EX;
                end
                ST_EX: begin
                    state_r  <= ST_WB;
                    cstate_r <= PH_WB;
                end
                ST_WB: begin
                    if (timeout_s) begin
                        state_r       <= ST_ERR;
                        cstate_r      <= PH_NONE;
                        timeout_err_r <= 1'b1;
                        step_pend_r   <= 1'b0;
                        step_inst_r   <= 1'b0;
                    end else if (phase_done_s) begin
                        retired_r <= retired_r + 32'd1;
                        // A step in this very cycle also forces a boundary stop
                        if (run && !stop_req && !step_pend_r && !step && !step_inst_r) begin
                            state_r     <= ST_IF;
                            cstate_r    <= PH_IF;
                            step_pend_r <= 1'b0;
                            step_inst_r <= 1'b0;
                        end else begin
                            state_r  <= ST_IDLE;
                            cstate_r <= PH_NONE;
                            halted_r <= 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    step_pend_r <= 1'b0;
                    if (clear) begin
                        state_r       <= ST_IDLE;
                        cstate_r      <= PH_NONE;
                        halted_r      <= 1'b1;
                        timeout_err_r <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cstate_r      <= PH_NONE;
                    halted_r      <= 1'b1;
                    timeout_err_r <= 1'b0;
                    step_pend_r   <= 1'b0;
                    step_inst_r   <= 1'b0;
                end
            endcase
        end
    end

    assign cstate      = cstate_r;
    assign phase_done  = phase_done_s;
    assign stall       = stall_s;
    assign halted      = halted_r;
    assign timeout_err = timeout_err_r;
    assign retired     = retired_r;

    phase_sequencer_checker u_checker (
        .clock      (clock),
        .reset      (reset),
        .cstate     (cstate_r),
        .phase_done (phase_done_s),
        .stall      (stall_s),
        .halted     (halted_r)
    );

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
// Directed stimulus for phase_sequencer. Each driven cycle pushes the
// hand-computed expected outputs for that cycle into a queue; a monitor on
// the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

    logic        clock;
    logic        reset;
    logic        run, step, stop_req, clear, mem_req, mem_ack;
    logic [3:0]  cstate;
    logic        phase_done, stall, halted, timeout_err;
    logic [31:0] retired;

    typedef struct packed {
        logic [3:0]  c;
        logic        pd;
        logic        st;
        logic        h;
        logic        te;
        logic [31:0] ret;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total;
    int    bad;
    logic [31:0] exp_ret;

    // Input bundle order: {run, step, stop_req, clear, mem_req, mem_ack}
    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_RUN  = 6'b100000;
    localparam logic [5:0] I_STEP = 6'b010000;
    localparam logic [5:0] I_STOP = 6'b001000;
    localparam logic [5:0] I_CLR  = 6'b000100;
    localparam logic [5:0] I_MQ   = 6'b000010;
    localparam logic [5:0] I_MA   = 6'b000001;

    phase_sequencer #(.WAIT_MAX(15), .TW(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .stop_req    (stop_req),
        .clear       (clear),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .cstate      (cstate),
        .phase_done  (phase_done),
        .stall       (stall),
        .halted      (halted),
        .timeout_err (timeout_err),
        .retired     (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total = total + 1;
        if (act !== expv) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: compare every expectation queued for the current cycle
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            chk({n, ".cstate"},      {28'd0, cstate},      {28'd0, e.c});
            chk({n, ".phase_done"},  {31'd0, phase_done},  {31'd0, e.pd});
            chk({n, ".stall"},       {31'd0, stall},       {31'd0, e.st});
            chk({n, ".halted"},      {31'd0, halted},      {31'd0, e.h});
            chk({n, ".timeout_err"}, {31'd0, timeout_err}, {31'd0, e.te});
            chk({n, ".retired"},     retired,              e.ret);
        end
    end

    // One clock cycle: drive inputs just after the edge, queue expected outputs
    task automatic cyc(input logic [5:0] in_v, input logic [3:0] ec, input logic epd,
                       input logic est, input logic eh, input logic ete, input string nm);
        exp_t e;
        @(posedge clock);
        #1;
        {run, step, stop_req, clear, mem_req, mem_ack} = in_v;
        e.c = ec; e.pd = epd; e.st = est; e.h = eh; e.te = ete; e.ret = exp_ret;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input logic [5:0] in_v, input string nm);
        cyc(in_v, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, nm);
    endtask

    task automatic ph(input logic [5:0] in_v, input logic [3:0] c, input string nm);
        cyc(in_v, c, 1'b1, 1'b0, 1'b0, 1'b0, nm);
    endtask

    task automatic stl(input logic [5:0] in_v, input logic [3:0] c, input string nm);
        cyc(in_v, c, 1'b0, 1'b1, 1'b0, 1'b0, nm);
    endtask

    task automatic err(input logic [5:0] in_v, input string nm);
        cyc(in_v, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, nm);
    endtask

    task automatic preload_retired(input logic [31:0] v);
        @(negedge clock);
        #1;
        force dut.retired_r = v;
        #1;
        release dut.retired_r;
        exp_ret = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; exp_ret = 32'd0;
        reset = 1'b1;
        {run, step, stop_req, clear, mem_req, mem_ack} = I_NONE;

        // Reset state
        idle(I_NONE, "rst_a");
        idle(I_NONE, "rst_b");
        reset = 1'b0;

        // 1: free run, zero wait states; run dropped in the last WB
        idle(I_RUN, "t1_start");
        for (int k = 0; k < 3; k++) begin
            ph(I_RUN | I_MQ | I_MA, 4'b0001, "t1_if");
            ph(I_RUN | I_MA, 4'b0010, "t1_de");
            ph(I_RUN | I_MA, 4'b0100, "t1_ex");
            ph((k == 2) ? I_MA : (I_RUN | I_MA), 4'b1000, "t1_wb");
            exp_ret = exp_ret + 32'd1;
        end
        idle(I_NONE, "t1_halt");

        // 2: single step
        idle(I_STEP, "t2_step");
        ph(I_MQ | I_MA, 4'b0001, "t2_if");
        ph(I_NONE, 4'b0010, "t2_de");
        ph(I_NONE, 4'b0100, "t2_ex");
        ph(I_NONE, 4'b1000, "t2_wb");
        exp_ret = exp_ret + 32'd1;
        idle(I_NONE, "t2_halt");
        idle(I_NONE, "t2_stay");

        // 3: IF ack after 3 stalls
        idle(I_STEP, "t3_step");
        repeat (3) stl(I_MQ, 4'b0001, "t3_if_wait");
        ph(I_MQ | I_MA, 4'b0001, "t3_if_ack");
        ph(I_NONE, 4'b0010, "t3_de");
        ph(I_NONE, 4'b0100, "t3_ex");
        ph(I_MQ | I_MA, 4'b1000, "t3_wb");
        exp_ret = exp_ret + 32'd1;
        idle(I_NONE, "t3_halt");

        // 3b: WB ack arrives exactly at the timeout boundary and wins
        idle(I_STEP, "t3b_step");
        ph(I_MQ | I_MA, 4'b0001, "t3b_if");
        ph(I_NONE, 4'b0010, "t3b_de");
        ph(I_NONE, 4'b0100, "t3b_ex");
        repeat (15) stl(I_MQ, 4'b1000, "t3b_wb_wait");
        ph(I_MQ | I_MA, 4'b1000, "t3b_wb_ack_at_limit");
        exp_ret = exp_ret + 32'd1;
        idle(I_NONE, "t3b_halt");

        // 4: IF never acked -> ERR, step/run ignored, clear recovers
        idle(I_STEP, "t4_step");
        repeat (16) stl(I_MQ, 4'b0001, "t4_if_wait");
        err(I_STEP | I_RUN, "t4_err_step");
        err(I_RUN, "t4_err_run");
        err(I_CLR, "t4_err_clear");
        idle(I_NONE, "t4_cleared");
        idle(I_NONE, "t4_no_pending_step");

        // 5: stop_req during DE
        idle(I_RUN, "t5_start");
        ph(I_RUN | I_MQ | I_MA, 4'b0001, "t5_if");
        ph(I_RUN | I_STOP, 4'b0010, "t5_de");
        ph(I_RUN | I_STOP, 4'b0100, "t5_ex");
        ph(I_RUN | I_STOP, 4'b1000, "t5_wb");
        exp_ret = exp_ret + 32'd1;
        idle(I_RUN | I_STOP, "t5_held_a");
        idle(I_RUN | I_STOP, "t5_held_b");
        idle(I_RUN, "t5_release");
        ph(I_RUN | I_MQ | I_MA, 4'b0001, "t5_if2");
        ph(I_NONE, 4'b0010, "t5_de2");
        ph(I_NONE, 4'b0100, "t5_ex2");
        ph(I_NONE, 4'b1000, "t5_wb2");
        exp_ret = exp_ret + 32'd1;
        idle(I_NONE, "t5_halt");

        // 6a: retire counter wraps
        preload_retired(32'hFFFF_FFFF);
        idle(I_STEP, "t6_preload");
        ph(I_MQ | I_MA, 4'b0001, "t6_if");
        ph(I_NONE, 4'b0010, "t6_de");
        ph(I_NONE, 4'b0100, "t6_ex");
        ph(I_NONE, 4'b1000, "t6_wb");
        exp_ret = 32'd0;
        idle(I_NONE, "t6_wrapped");

        // 6b: asynchronous reset in the middle of a WB stall
        preload_retired(32'hFFFF_FFFF);
        idle(I_STEP, "t6b_step");
        ph(I_MQ | I_MA, 4'b0001, "t6b_if");
        ph(I_NONE, 4'b0010, "t6b_de");
        ph(I_NONE, 4'b0100, "t6b_ex");
        stl(I_MQ, 4'b1000, "t6b_wb_wait_a");
        stl(I_MQ, 4'b1000, "t6b_wb_wait_b");
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("t6b_async.cstate",      {28'd0, cstate},      32'd0);
        chk("t6b_async.retired",     retired,              32'd0);
        chk("t6b_async.halted",      {31'd0, halted},      32'd1);
        chk("t6b_async.stall",       {31'd0, stall},       32'd0);
        chk("t6b_async.phase_done",  {31'd0, phase_done},  32'd0);
        chk("t6b_async.timeout_err", {31'd0, timeout_err}, 32'd0);
        exp_ret = 32'd0;
        idle(I_NONE, "t6b_in_reset");
        reset = 1'b0;
        idle(I_NONE, "t6b_after_reset");

        @(posedge clock);
        @(negedge clock);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
